door_plant: RTL and testbench

DOOR_PLANT -- requirements
Module: door_plant

---
 rtl/door_plant.sv | 187 ++++++++++++++++++
 tb/tb_door_plant.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/door_plant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | door_plant: behavioural door plant with motor drive, limits, stall and     |
// | conflict faults.                                                           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module door_plant #(
  parameter int TRAVEL   = 8,
  parameter int STEP_DIV = 2,
  parameter int STALL    = 4,
  parameter int INIT_UP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       motor_up,
  input  logic       motor_dn,
  input  logic       clear_fault,
  output logic       up_limit,
  output logic       dn_limit,
  output logic [7:0] position,
  output logic       moving,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UP    = 2'd1,
    S_DN    = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] TRAVEL_C   = 8'(TRAVEL);
  localparam logic [7:0] DIV_LAST_C = 8'(STEP_DIV - 1);
  localparam logic [7:0] STALL_C    = 8'(STALL);
  localparam logic       RST_UP_C   = (INIT_UP != 0);
  localparam logic [7:0] POS_RST_C  = RST_UP_C ? TRAVEL_C : 8'd0;

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_CONFLICT = 2'd1;
  localparam logic [1:0] CODE_STALL    = 2'd2;

  state_t     state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] stall_q, stall_d;
  logic [7:0] position_q, position_d;
  logic       up_limit_q, up_limit_d;
  logic       dn_limit_q, dn_limit_d;
  logic       moving_q, moving_d;
  logic       fault_q, fault_d;
  logic [1:0] fault_code_q, fault_code_d;

  logic       conflict;
  logic       stall_hit;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    stall_d      = stall_q;
    position_d   = position_q;
    fault_code_d = fault_code_q;
    conflict     = motor_up & motor_dn;
    stall_hit    = (motor_up & up_limit_q) | (motor_dn & dn_limit_q);

    if (state_q != S_FAULT) begin
      // Saturate so a very long push against a limit can never wrap to 0.
      if (!stall_hit) begin
        stall_d = 8'd0;
      end else if (stall_q != 8'hFF) begin
        stall_d = stall_q + 8'd1;
      end

      if (conflict) begin
        state_d      = S_FAULT;
        fault_code_d = CODE_CONFLICT;
        presc_d      = 8'd0;
      end else if (stall_d >= STALL_C) begin
        state_d      = S_FAULT;
        fault_code_d = CODE_STALL;
        presc_d      = 8'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            presc_d = 8'd0;
            if (motor_up && (position_q < TRAVEL_C)) begin
              state_d = S_UP;
            end else if (motor_dn && (position_q != 8'd0)) begin
              state_d = S_DN;
            end
          end
          S_UP: begin
            if (motor_up) begin
              if (presc_q >= DIV_LAST_C) begin
                presc_d = 8'd0;
                if (position_q < TRAVEL_C) begin
                  position_d = position_q + 8'd1;
                end
                if (position_d == TRAVEL_C) begin
                  state_d = S_IDLE;
                end
              end else begin
                presc_d = presc_q + 8'd1;
              end
            end else if (motor_dn && (position_q != 8'd0)) begin
              state_d = S_DN;
              presc_d = 8'd0;
            end else begin
              state_d = S_IDLE;
              presc_d = 8'd0;
            end
          end
          S_DN: begin
            if (motor_dn) begin
              if (presc_q >= DIV_LAST_C) begin
                presc_d = 8'd0;
                if (position_q != 8'd0) begin
                  position_d = position_q - 8'd1;
                end
                if (position_d == 8'd0) begin
                  state_d = S_IDLE;
                end
              end else begin
                presc_d = presc_q + 8'd1;
              end
            end else if (motor_up && (position_q < TRAVEL_C)) begin
              state_d = S_UP;
              presc_d = 8'd0;
            end else begin
              state_d = S_IDLE;
              presc_d = 8'd0;
            end
          end
          default: begin
            state_d = S_IDLE;
            presc_d = 8'd0;
          end
        endcase
      end
    end else begin
      // Leaving FAULT needs the controller to have released both commands.
      if (clear_fault && !motor_up && !motor_dn) begin
        state_d      = S_IDLE;
        fault_code_d = CODE_NONE;
        stall_d      = 8'd0;
        presc_d      = 8'd0;
      end
    end

    up_limit_d = (position_d == TRAVEL_C);
    dn_limit_d = (position_d == 8'd0);
    moving_d   = (state_d == S_UP) || (state_d == S_DN);
    fault_d    = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      presc_q      <= 8'd0;
      stall_q      <= 8'd0;
      position_q   <= POS_RST_C;
      up_limit_q   <= RST_UP_C;
      dn_limit_q   <= !RST_UP_C;
      moving_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      stall_q      <= stall_d;
      position_q   <= position_d;
      up_limit_q   <= up_limit_d;
      dn_limit_q   <= dn_limit_d;
      moving_q     <= moving_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign up_limit   = up_limit_q;
  assign dn_limit   = dn_limit_q;
  assign position   = position_q;
  assign moving     = moving_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
`default_nettype wire

// File: tb/tb_door_plant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_door_plant: scenario bench for door_plant with default parameters.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_door_plant;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       motor_up;
  logic       motor_dn;
  logic       clear_fault;
  logic       up_limit;
  logic       dn_limit;
  logic [7:0] position;
  logic       moving;
  logic       fault;
  logic [1:0] fault_code;

  logic [13:0] obs;
  logic [13:0] sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  door_plant #(
    .TRAVEL  (8),
    .STEP_DIV(2),
    .STALL   (4),
    .INIT_UP (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .motor_up   (motor_up),
    .motor_dn   (motor_dn),
    .clear_fault(clear_fault),
    .up_limit   (up_limit),
    .dn_limit   (dn_limit),
    .position   (position),
    .moving     (moving),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  assign obs = {position, up_limit, dn_limit, moving, fault, fault_code};

  // Expected output word: {position, up_limit, dn_limit, moving, fault, fault_code}.
  function automatic logic [13:0] pk(input int p, input logic u, input logic d,
                                     input logic m, input logic f, input logic [1:0] c);
    return {8'(p), u, d, m, f, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    rst_n = 1'b0; motor_up = 1'b0; motor_dn = 1'b0; clear_fault = 1'b0;
    repeat (2) tick();
    sb.push_back(pk(8, 1, 0, 0, 0, 0));
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_hold: got pos=%0d flags=%b want pos=%0d flags=%b", obs[13:6], obs[5:0], e[13:6], e[5:0]);
    end
    rst_n = 1'b1;
    sb.push_back(pk(8, 1, 0, 0, 0, 0));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_release: got pos=%0d flags=%b want pos=%0d flags=%b", obs[13:6], obs[5:0], e[13:6], e[5:0]);
    end
  endtask

  // 8 -> 0: one IDLE->DN edge, then a step every second edge.
  task automatic test_descent();
    logic [13:0] e;
    int p;
    motor_dn = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      p = (k == 1) ? 8 : 8 - (k - 1) / 2;
      sb.push_back(pk(p, p == 8, p == 0, k < 17, 0, 0));
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL descent k=%0d: got pos=%0d flags=%b want pos=%0d flags=%b", k, obs[13:6], obs[5:0], e[13:6], e[5:0]);
      end
    end
    motor_dn = 1'b0;
    sb.push_back(pk(0, 0, 1, 0, 0, 0));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL descent_rest: got pos=%0d flags=%b want pos=%0d flags=%b", obs[13:6], obs[5:0], e[13:6], e[5:0]);
    end
  endtask

  task automatic test_stall();
    logic [13:0] e;
    motor_dn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      sb.push_back((k < 4) ? pk(0, 0, 1, 0, 0, 0) : pk(0, 0, 1, 0, 1, 2));
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL stall k=%0d: got pos=%0d flags=%b want pos=%0d flags=%b", k, obs[13:6], obs[5:0], e[13:6], e[5:0]);
      end
    end
    motor_dn = 1'b0;
    sb.push_back(pk(0, 0, 1, 0, 1, 2));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL stall_hold: got pos=%0d flags=%b want pos=%0d flags=%b", obs[13:6], obs[5:0], e[13:6], e[5:0]);
    end
    clear_fault = 1'b1;
    sb.push_back(pk(0, 0, 1, 0, 0, 0));
    tick();
    clear_fault = 1'b0;
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL stall_clear: got pos=%0d flags=%b want pos=%0d flags=%b", obs[13:6], obs[5:0], e[13:6], e[5:0]);
    end
  endtask

  // 0 -> 8, then three cycles pushing into up_limit stay below the stall threshold.
  task automatic test_ascent();
    logic [13:0] e;
    int p;
    motor_up = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      if (k == 21) motor_up = 1'b0;
      p = (k == 1) ? 0 : ((k <= 17) ? (k - 1) / 2 : 8);
      sb.push_back(pk(p, p == 8, p == 0, k < 17, 0, 0));
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL ascent k=%0d: got pos=%0d flags=%b want pos=%0d flags=%b", k, obs[13:6], obs[5:0], e[13:6], e[5:0]);
      end
    end
  endtask

  task automatic test_conflict();
    logic [13:0] e;
    int p;
    motor_dn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      p = (k == 1) ? 8 : 8 - (k - 1) / 2;
      sb.push_back(pk(p, p == 8, 0, 1, 0, 0));
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL conflict_pre k=%0d: got pos=%0d flags=%b want pos=%0d flags=%b", k, obs[13:6], obs[5:0], e[13:6], e[5:0]);
      end
    end
    motor_up = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin motor_dn = 1'b0; clear_fault = 1'b1; end
      if (k == 4) motor_up = 1'b0;
      sb.push_back((k < 4) ? pk(6, 0, 0, 0, 1, 1) : pk(6, 0, 0, 0, 0, 0));
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL conflict k=%0d: got pos=%0d flags=%b want pos=%0d flags=%b", k, obs[13:6], obs[5:0], e[13:6], e[5:0]);
      end
    end
    clear_fault = 1'b0;
  endtask

  // Reverse one cycle after a step, while the prescaler is mid-count.
  task automatic test_reversal();
    logic [13:0] e;
    int p;
    motor_dn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 7) begin motor_dn = 1'b0; motor_up = 1'b1; end
      if (k == 10) motor_up = 1'b0;
      if (k <= 6)      p = (k == 1) ? 6 : 6 - (k - 1) / 2;
      else if (k <= 8) p = 4;
      else             p = 5;
      sb.push_back(pk(p, 0, 0, k < 10, 0, 0));
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reversal k=%0d: got pos=%0d flags=%b want pos=%0d flags=%b", k, obs[13:6], obs[5:0], e[13:6], e[5:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    int p;
    motor_dn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      p = (k == 1) ? 5 : 5 - (k - 1) / 2;
      sb.push_back(pk(p, 0, 0, 1, 0, 0));
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_pre k=%0d: got pos=%0d flags=%b want pos=%0d flags=%b", k, obs[13:6], obs[5:0], e[13:6], e[5:0]);
      end
    end
    rst_n = 1'b0;
    sb.push_back(pk(8, 1, 0, 0, 0, 0));
    #2;
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_mid_async: got pos=%0d flags=%b want pos=%0d flags=%b", obs[13:6], obs[5:0], e[13:6], e[5:0]);
    end
    sb.push_back(pk(8, 1, 0, 0, 0, 0));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_mid_held: got pos=%0d flags=%b want pos=%0d flags=%b", obs[13:6], obs[5:0], e[13:6], e[5:0]);
    end
    motor_dn = 1'b0;
    rst_n = 1'b1;
    sb.push_back(pk(8, 1, 0, 0, 0, 0));
    tick();
    e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_mid_release: got pos=%0d flags=%b want pos=%0d flags=%b", obs[13:6], obs[5:0], e[13:6], e[5:0]);
    end
  endtask

  // Stall and conflict land on the same edge; conflict code must win.
  task automatic test_priority();
    logic [13:0] e;
    motor_up = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) motor_dn = 1'b1;
      if (k == 5) begin motor_up = 1'b0; motor_dn = 1'b0; clear_fault = 1'b1; end
      sb.push_back((k == 4) ? pk(8, 1, 0, 0, 1, 1) : pk(8, 1, 0, 0, 0, 0));
      tick();
      e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL priority k=%0d: got pos=%0d flags=%b want pos=%0d flags=%b", k, obs[13:6], obs[5:0], e[13:6], e[5:0]);
      end
    end
    clear_fault = 1'b0;
  endtask

  initial begin
    test_reset();
    test_descent();
    test_stall();
    test_ascent();
    test_conflict();
    test_reversal();
    test_reset_mid();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
